// File: rtl/mc_ctrl_pkg.sv
// Shared state encoding, opcode constants, datapath select codes and control bundle
// for the multi-cycle RISC control FSM.
package mc_ctrl_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OPC_W   = 7;

  typedef enum logic [STATE_W-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    LOAD_RD  = 4'd3,
    LOAD_WB  = 4'd4,
    STORE_WR = 4'd5,
    EXEC     = 4'd6,
    ALU_WB   = 4'd7,
    BRANCH   = 4'd8,
    JAL      = 4'd9,
    TRAP     = 4'd10
  } state_e;

  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_SUB    = 2'b01;
  localparam logic [1:0] ALUOP_RFUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IFUNCT = 2'b11;

  localparam logic [1:0] RD_ALUOUT = 2'b00;
  localparam logic [1:0] RD_MDR    = 2'b01;
  localparam logic [1:0] RD_PC     = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       alu_src_a;
    logic       reg_write;
    logic       illegal_instr;
    logic       instr_retired;
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] rd_src;
  } ctrl_t;

  // Dispatch target out of DECODE for a given opcode.
  function automatic state_e decode_target(input logic [OPC_W-1:0] opcode);
    state_e tgt;
    tgt = TRAP;
    case (opcode)
      OP_LOAD, OP_STORE: tgt = MEM_ADDR;
      OP_RTYPE, OP_ITYPE: tgt = EXEC;
      OP_BRANCH: tgt = BRANCH;
      OP_JAL: tgt = JAL;
      default: tgt = TRAP;
    endcase
    return tgt;
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Moore output decoder: control bundle from current state; only memory-handshake
// qualified strobes look at mem_ready.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_e            state,
  input  logic              mem_ready,
  input  logic [OPC_W-1:0]  opcode,
  output ctrl_t             ctrl_c
);

  always_comb begin
    ctrl_c = '0;
    case (state)
      FETCH: begin
        ctrl_c.mem_read  = 1'b1;
        ctrl_c.alu_src_b = SRCB_FOUR;
        ctrl_c.alu_op    = ALUOP_ADD;
        ctrl_c.pc_source = PCS_ALU;
        ctrl_c.ir_write  = mem_ready;
        ctrl_c.pc_write  = mem_ready;
      end
      DECODE: begin
        ctrl_c.alu_src_b = SRCB_IMM;
        ctrl_c.alu_op    = ALUOP_ADD;
      end
      MEM_ADDR: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_IMM;
        ctrl_c.alu_op    = ALUOP_ADD;
      end
      LOAD_RD: begin
        ctrl_c.mem_read = 1'b1;
        ctrl_c.i_or_d   = 1'b1;
      end
      LOAD_WB: begin
        ctrl_c.reg_write     = 1'b1;
        ctrl_c.rd_src        = RD_MDR;
        ctrl_c.instr_retired = 1'b1;
      end
      STORE_WR: begin
        ctrl_c.mem_write     = 1'b1;
        ctrl_c.i_or_d        = 1'b1;
        ctrl_c.instr_retired = mem_ready;
      end
      EXEC: begin
        ctrl_c.alu_src_a = 1'b1;
        if (opcode == OP_RTYPE) begin
          ctrl_c.alu_src_b = SRCB_B;
          ctrl_c.alu_op    = ALUOP_RFUNCT;
        end else begin
          ctrl_c.alu_src_b = SRCB_IMM;
          ctrl_c.alu_op    = ALUOP_IFUNCT;
        end
      end
      ALU_WB: begin
        ctrl_c.reg_write     = 1'b1;
        ctrl_c.rd_src        = RD_ALUOUT;
        ctrl_c.instr_retired = 1'b1;
      end
      BRANCH: begin
        ctrl_c.alu_src_a     = 1'b1;
        ctrl_c.alu_src_b     = SRCB_B;
        ctrl_c.alu_op        = ALUOP_SUB;
        ctrl_c.pc_write_cond = 1'b1;
        ctrl_c.pc_source     = PCS_ALUOUT;
        ctrl_c.instr_retired = 1'b1;
      end
      JAL: begin
        ctrl_c.pc_write      = 1'b1;
        ctrl_c.pc_source     = PCS_ALUOUT;
        ctrl_c.reg_write     = 1'b1;
        ctrl_c.rd_src        = RD_PC;
        ctrl_c.instr_retired = 1'b1;
      end
      TRAP: ctrl_c.illegal_instr = 1'b1;
      default: ctrl_c = '0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle processor control FSM with state register, next-state logic and optional
// performance counters (enabled by defining MC_CTRL_PERF_EN).
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W              = 32,
  parameter bit          FETCH_ALWAYS_READY = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       instruction,
  input  logic              mem_ready,
  output logic              pc_write,
  output logic              pc_write_cond,
  output logic              i_or_d,
  output logic              mem_read,
  output logic              mem_write,
  output logic              ir_write,
  output logic              alu_src_a,
  output logic              reg_write,
  output logic              illegal_instr,
  output logic              instr_retired,
  output logic [1:0]        pc_source,
  output logic [1:0]        alu_src_b,
  output logic [1:0]        alu_op,
  output logic [1:0]        rd_src,
  output logic [3:0]        state,
  output logic [3:0]        next_state,
  output logic [CNT_W-1:0]  perf_cycles,
  output logic [CNT_W-1:0]  perf_instret
);

  state_e             state_q, state_d;
  logic [OPC_W-1:0]   opcode;
  logic               mem_ready_eff;
  ctrl_t              ctrl;
  logic               unused_instr_bits;

  assign opcode            = instruction[OPC_W-1:0];
  assign unused_instr_bits = ^instruction[31:OPC_W];
  assign mem_ready_eff     = mem_ready | (FETCH_ALWAYS_READY && (state_q == FETCH));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Memory states wait on mem_ready; every other state advances unconditionally.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = mem_ready_eff ? DECODE : FETCH;
      DECODE:   state_d = decode_target(opcode);
      MEM_ADDR: state_d = (opcode == OP_LOAD) ? LOAD_RD : STORE_WR;
      LOAD_RD:  state_d = mem_ready_eff ? LOAD_WB : LOAD_RD;
      STORE_WR: state_d = mem_ready_eff ? FETCH : STORE_WR;
      EXEC:     state_d = ALU_WB;
      default:  state_d = FETCH;
    endcase
  end

  mc_ctrl_decode u_decode (
    .state     (state_q),
    .mem_ready (mem_ready_eff),
    .opcode    (opcode),
    .ctrl_c    (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign reg_write     = ctrl.reg_write;
  assign illegal_instr = ctrl.illegal_instr;
  assign instr_retired = ctrl.instr_retired;
  assign pc_source     = ctrl.pc_source;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign rd_src        = ctrl.rd_src;
  assign state         = state_q;
  assign next_state    = state_d;

`ifdef MC_CTRL_PERF_EN
  logic [CNT_W-1:0] cycles_q, cycles_d, instret_q, instret_d;

  // Free-running counters, wrapping naturally at 2^CNT_W.
  always_comb begin
    cycles_d  = cycles_q + CNT_W'(1);
    instret_d = instret_q + CNT_W'(ctrl.instr_retired);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycles_q  <= '0;
      instret_q <= '0;
    end else begin
      cycles_q  <= cycles_d;
      instret_q <= instret_d;
    end
  end

  assign perf_cycles  = cycles_q;
  assign perf_instret = instret_q;
`else
  assign perf_cycles  = '0;
  assign perf_instret = '0;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: directed scenarios plus a randomized
// instruction stream checked against an instruction-level path model.
module tb_mc_control_fsm;

  localparam int unsigned CNT_W = 8;
`ifdef MC_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic [31:0]       instruction;
  logic              mem_ready;
  logic              pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic              alu_src_a, reg_write, illegal_instr, instr_retired;
  logic [1:0]        pc_source, alu_src_b, alu_op, rd_src;
  logic [3:0]        state, next_state;
  logic [CNT_W-1:0]  perf_cycles, perf_instret;
  logic [17:0]       obs_ctrl;

  int n_pass = 0;
  int n_chk  = 0;

  mc_control_fsm #(.CNT_W(CNT_W), .FETCH_ALWAYS_READY(1'b0)) dut (
    .clock(clock), .reset(reset), .instruction(instruction), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .alu_src_a(alu_src_a), .reg_write(reg_write), .illegal_instr(illegal_instr),
    .instr_retired(instr_retired), .pc_source(pc_source), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .rd_src(rd_src), .state(state), .next_state(next_state),
    .perf_cycles(perf_cycles), .perf_instret(perf_instret)
  );

  always #5 clock = ~clock;

  assign obs_ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                     alu_src_a, reg_write, illegal_instr, instr_retired,
                     pc_source, alu_src_b, alu_op, rd_src};

  // Required control values for a state, straight from the state/output table.
  function automatic logic [17:0] exp_ctrl(input int st, input logic mr, input logic [6:0] op);
    logic pw, pwc, iod, mrd, mwr, irw, asa, rw, ill, ret;
    logic [1:0] pcs, asb, aop, rds;
    {pw, pwc, iod, mrd, mwr, irw, asa, rw, ill, ret} = '0;
    {pcs, asb, aop, rds} = '0;
    case (st)
      0: begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
      1: asb = 2'b10;
      2: begin asa = 1; asb = 2'b10; end
      3: begin mrd = 1; iod = 1; end
      4: begin rw = 1; rds = 2'b01; ret = 1; end
      5: begin mwr = 1; iod = 1; ret = mr; end
      6: begin
        asa = 1;
        if (op == 7'b0110011) begin asb = 2'b00; aop = 2'b10; end
        else begin asb = 2'b10; aop = 2'b11; end
      end
      7: begin rw = 1; ret = 1; end
      8: begin asa = 1; aop = 2'b01; pwc = 1; pcs = 2'b01; ret = 1; end
      9: begin pw = 1; pcs = 2'b01; rw = 1; rds = 2'b10; ret = 1; end
      10: ill = 1;
      default: ;
    endcase
    return {pw, pwc, iod, mrd, mwr, irw, asa, rw, ill, ret, pcs, asb, aop, rds};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b0; instruction = 32'h0;
    #2;
    n_chk++; if (state !== 4'd0) $display("FAIL reset_state: got %0d want 0", state); else n_pass++;
    n_chk++; if (next_state !== 4'd0) $display("FAIL reset_next: got %0d want 0", next_state); else n_pass++;
    n_chk++; if (obs_ctrl !== exp_ctrl(0, 1'b0, 7'd0))
      $display("FAIL reset_ctrl: got %h want %h", obs_ctrl, exp_ctrl(0, 1'b0, 7'd0)); else n_pass++;
    n_chk++; if ({perf_cycles, perf_instret} !== '0)
      $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_cycles, perf_instret); else n_pass++;
    mem_ready = 1'b1;
    #1;
    n_chk++; if (obs_ctrl !== exp_ctrl(0, 1'b1, 7'd0))
      $display("FAIL reset_fetch_ready: got %h want %h", obs_ctrl, exp_ctrl(0, 1'b1, 7'd0)); else n_pass++;
    tick();
    n_chk++; if (state !== 4'd0) $display("FAIL reset_hold: got %0d want 0", state); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_add();
    int exp_st [5];
    int rets = 0;
    exp_st = '{0, 1, 6, 7, 0};
    do_reset();
    instruction = 32'h002081B3; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_chk++; if (state !== 4'(exp_st[i]))
        $display("FAIL add_state[%0d]: got %0d want %0d", i, state, exp_st[i]); else n_pass++;
      if (i == 3) begin
        n_chk++; if ({reg_write, rd_src} !== 3'b100)
          $display("FAIL add_wb: got rw=%b rd_src=%b want rw=1 rd_src=00", reg_write, rd_src); else n_pass++;
      end
      if (i < 4) rets += int'(instr_retired);
      tick();
    end
    n_chk++; if (rets != 1) $display("FAIL add_retire: got %0d want 1", rets); else n_pass++;
  endtask

  task automatic test_load_wait();
    int exp_st [9];
    logic mr_plan [9];
    int rd_cycles = 0;
    exp_st  = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
    mr_plan = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    instruction = 32'h0000A183;
    for (int i = 0; i < 9; i++) begin
      mem_ready = mr_plan[i];
      #1;
      n_chk++; if (state !== 4'(exp_st[i]))
        $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, exp_st[i]); else n_pass++;
      if (state == 4'd3) begin
        rd_cycles++;
        n_chk++; if ({mem_read, i_or_d} !== 2'b11)
          $display("FAIL lw_mem_read[%0d]: got %b%b want 11", i, mem_read, i_or_d); else n_pass++;
      end
      if (state == 4'd4) begin
        n_chk++; if ({reg_write, rd_src} !== 3'b101)
          $display("FAIL lw_wb: got rw=%b rd_src=%b want rw=1 rd_src=01", reg_write, rd_src); else n_pass++;
      end
      tick();
    end
    n_chk++; if (rd_cycles != 4) $display("FAIL lw_hold: got %0d want 4", rd_cycles); else n_pass++;
  endtask

  task automatic test_trap();
    int exp_st [4];
    int ills = 0;
    int rets = 0;
    exp_st = '{0, 1, 10, 0};
    do_reset();
    instruction = 32'h0000007F; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_chk++; if (state !== 4'(exp_st[i]))
        $display("FAIL trap_state[%0d]: got %0d want %0d", i, state, exp_st[i]); else n_pass++;
      if (state == 4'd10) begin
        n_chk++; if ({reg_write, mem_write, pc_write, pc_write_cond} !== 4'b0)
          $display("FAIL trap_writes: got %b want 0000",
                   {reg_write, mem_write, pc_write, pc_write_cond}); else n_pass++;
      end
      ills += int'(illegal_instr);
      rets += int'(instr_retired);
      if (i < 3) tick();
    end
    n_chk++; if (ills != 1) $display("FAIL trap_illegal: got %0d want 1", ills); else n_pass++;
    n_chk++; if (rets != 0) $display("FAIL trap_retire: got %0d want 0", rets); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_store();
    logic mr_plan [5];
    mr_plan = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    instruction = 32'h0020A023;
    for (int i = 0; i < 5; i++) begin
      mem_ready = mr_plan[i];
      tick();
    end
    mem_ready = 1'b0;
    #1;
    n_chk++; if ({state, mem_write} !== {4'd5, 1'b1})
      $display("FAIL sw_wait: got state=%0d mw=%b want 5/1", state, mem_write); else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    n_chk++; if ({state, mem_write, instr_retired} !== {4'd0, 1'b0, 1'b0})
      $display("FAIL sw_reset: got state=%0d mw=%b ret=%b want 0/0/0", state, mem_write, instr_retired);
    else n_pass++;
    n_chk++; if ({perf_cycles, perf_instret} !== '0)
      $display("FAIL sw_reset_perf: got %0d/%0d want 0/0", perf_cycles, perf_instret); else n_pass++;
    mem_ready = 1'b1;
    tick();
    n_chk++; if (state !== 4'd0) $display("FAIL sw_reset_hold: got %0d want 0", state); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    int rets = 0;
    do_reset();
    instruction = 32'h002081B3; mem_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      #1;
      rets += int'(instr_retired);
      tick();
    end
    #1;
    n_chk++; if (perf_cycles !== CNT_W'(PERF ? 44 : 0))
      $display("FAIL b2b_cycles: got %0d want %0d", perf_cycles, PERF ? 44 : 0); else n_pass++;
    n_chk++; if (perf_instret !== CNT_W'(PERF ? 75 : 0))
      $display("FAIL b2b_instret: got %0d want %0d", perf_instret, PERF ? 75 : 0); else n_pass++;
    n_chk++; if (rets != 75) $display("FAIL b2b_pulses: got %0d want 75", rets); else n_pass++;
    tick();
  endtask

  typedef struct packed {
    logic [3:0]  st;
    logic        mr;
    logic [31:0] ins;
  } cyc_t;

  cyc_t path_q [$];

  function automatic void push(input int st, input logic mr, input logic [31:0] ins);
    cyc_t c;
    c.st = 4'(st); c.mr = mr; c.ins = ins;
    path_q.push_back(c);
  endfunction

  function automatic bit is_known(input logic [6:0] op);
    return op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
  endfunction

  // Expand one instruction into its expected per-cycle path; returns 1 if it retires.
  function automatic int add_instr(input logic [6:0] op, input int fw, input int mw);
    logic [31:0] ins;
    ins = {25'($urandom), op};
    for (int k = 0; k < fw; k++) push(0, 1'b0, ins);
    push(0, 1'b1, ins);
    push(1, 1'($urandom), ins);
    case (op)
      7'b0000011: begin
        push(2, 1'($urandom), ins);
        for (int k = 0; k < mw; k++) push(3, 1'b0, ins);
        push(3, 1'b1, ins);
        push(4, 1'($urandom), ins);
      end
      7'b0100011: begin
        push(2, 1'($urandom), ins);
        for (int k = 0; k < mw; k++) push(5, 1'b0, ins);
        push(5, 1'b1, ins);
      end
      7'b0110011, 7'b0010011: begin
        push(6, 1'($urandom), ins);
        push(7, 1'($urandom), ins);
      end
      7'b1100011: push(8, 1'($urandom), ins);
      7'b1101111: push(9, 1'($urandom), ins);
      default: begin
        push(10, 1'($urandom), ins);
        return 0;
      end
    endcase
    return 1;
  endfunction

  task automatic test_random();
    logic [6:0] ops [6];
    logic [6:0] op;
    int exp_ret_total = 0;
    int model_ret = 0;
    int obs_rets = 0;
    int cyc = 0;
    logic [17:0] ec;
    logic [3:0] en;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
    path_q.delete();
    for (int n = 0; n < 40; n++) begin
      int r;
      r = int'($urandom_range(0, 6));
      if (r < 6) op = ops[r];
      else begin
        op = 7'($urandom);
        while (is_known(op)) op = 7'($urandom);
      end
      exp_ret_total += add_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    do_reset();
    for (int idx = 0; idx < path_q.size(); idx++) begin
      instruction = path_q[idx].ins;
      mem_ready   = path_q[idx].mr;
      #1;
      ec = exp_ctrl(int'(path_q[idx].st), path_q[idx].mr, path_q[idx].ins[6:0]);
      en = (idx + 1 < path_q.size()) ? path_q[idx + 1].st : 4'd0;
      n_chk++; if ({state, next_state, obs_ctrl} !== {path_q[idx].st, en, ec})
        $display("FAIL rand_cycle[%0d]: got st=%0d nx=%0d ctrl=%h want st=%0d nx=%0d ctrl=%h",
                 idx, state, next_state, obs_ctrl, path_q[idx].st, en, ec);
      else n_pass++;
      n_chk++; if ({perf_cycles, perf_instret} !== {CNT_W'(PERF ? cyc : 0), CNT_W'(PERF ? model_ret : 0)})
        $display("FAIL rand_perf[%0d]: got %0d/%0d want %0d/%0d", idx, perf_cycles, perf_instret,
                 CNT_W'(PERF ? cyc : 0), CNT_W'(PERF ? model_ret : 0));
      else n_pass++;
      model_ret += int'(ec[8]);
      obs_rets  += int'(instr_retired);
      cyc++;
      tick();
    end
    n_chk++; if (obs_rets != exp_ret_total)
      $display("FAIL rand_retired: got %0d want %0d", obs_rets, exp_ret_total); else n_pass++;
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0; instruction = 32'h0;
    test_reset();
    test_add();
    test_load_wait();
    test_trap();
    test_reset_mid_store();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
